// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM.
// Optional illegal-opcode trap state is used when MC_ILLEGAL_TRAP_EN is set.
package mc_control_fsm_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_OP_ADD   = 3'd0;
  localparam logic [2:0] ALU_OP_SUB   = 3'd1;
  localparam logic [2:0] ALU_OP_AND   = 3'd2;
  localparam logic [2:0] ALU_OP_OR    = 3'd3;
  localparam logic [2:0] ALU_OP_FUNCT = 3'd4;

  localparam logic [1:0] ALUSRCB_RT      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] r;
    r = ALU_OP_ADD;
    if (op == OP_ANDI) r = ALU_OP_AND;
    if (op == OP_ORI)  r = ALU_OP_OR;
    return r;
  endfunction

  // Logical immediates are zero-extended, addi is sign-extended.
  function automatic logic imm_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_control_fsm_output_decode.sv
// Combinational state/opcode to datapath-control decode.
// Drives illegal_instr only when MC_ILLEGAL_TRAP_EN is defined.
module mc_control_fsm_output_decode
  import mc_control_fsm_pkg::*;
(
  input  logic       rst,
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       ext_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic       illegal_instr,
`endif
  output logic [1:0] pc_src
);

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    ext_sel    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUSRCB_RT;
    alu_op     = ALU_OP_ADD;
    pc_src     = PCSRC_ALU;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    // Reset wins over state so a pending access is dropped at once.
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = ALUSRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = ALUSRCB_IMM_SH2;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUSRCB_IMM;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          i_or_d  = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_OP_FUNCT;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_OP_SUB;
          pc_src    = PCSRC_ALUOUT;
          pc_write  = (opcode == OP_BNE) ? ~zero : zero;
        end
        S_IMMEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUSRCB_IMM;
          ext_sel   = imm_zext(opcode);
          alu_op    = imm_alu_op(opcode);
        end
        S_IMMWB: begin
          reg_write = 1'b1;
          ext_sel   = imm_zext(opcode);
          alu_op    = imm_alu_op(opcode);
        end
        S_JUMP: begin
          pc_src   = PCSRC_JUMP;
          pc_write = 1'b1;
        end
`ifdef MC_ILLEGAL_TRAP_EN
        S_TRAP: begin
          illegal_instr = 1'b1;
          pc_src        = PCSRC_EXC;
          pc_write      = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: state register and next-state logic.
// MC_ILLEGAL_TRAP_EN adds the S_TRAP state and the illegal_instr output.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int     S_W         = STATE_W,
  parameter state_e RESET_STATE = S_FETCH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [5:0]     opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           i_or_d,
  output logic           ir_write,
  output logic           pc_write,
  output logic           reg_write,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           ext_sel,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [2:0]     alu_op,
  output logic [1:0]     pc_src,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic           illegal_instr,
`endif
  output logic [S_W-1:0] state_dbg
);

  state_e state_q;
  state_e state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:
        if (mem_ready) state_d = S_DECODE;
      S_DECODE:
        case (opcode)
          OP_LW, OP_SW:              state_d = S_MEMADR;
          OP_RTYPE:                  state_d = S_EXEC;
          OP_BEQ, OP_BNE:            state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IMMEXEC;
          OP_J:                      state_d = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
          default:                   state_d = S_TRAP;
`else
          default:                   state_d = S_FETCH;
`endif
        endcase
      S_MEMADR:
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:
        if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:
        if (mem_ready) state_d = S_FETCH;
      S_EXEC:    state_d = S_ALUWB;
      S_IMMEXEC: state_d = S_IMMWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RESET_STATE;
    else     state_q <= state_d;
  end

  assign state_dbg = rst ? '0 : S_W'(state_q);

  mc_control_fsm_output_decode u_dec (
    .rst        (rst),
    .state      (state_q),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .ext_sel    (ext_sel),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
`ifdef MC_ILLEGAL_TRAP_EN
    .illegal_instr(illegal_instr),
`endif
    .pc_src     (pc_src)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed scoreboard bench for mc_control_fsm.
// Covers both builds of MC_ILLEGAL_TRAP_EN.
module tb_mc_control_fsm;
  import mc_control_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d;
  logic       ir_write, pc_write, reg_write;
  logic       reg_dst, mem_to_reg, ext_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;
  logic       illegal;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .ext_sel    (ext_sel),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
`ifdef MC_ILLEGAL_TRAP_EN
    .illegal_instr(illegal),
`endif
    .state_dbg  (state_dbg)
  );

`ifndef MC_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  // {state, mem_req, mem_we, i_or_d, ir_w, pc_w, reg_w,
  //  reg_dst, m2r, ext, asa, asb, alu_op, pc_src, illegal}
  typedef struct {
    logic [21:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [21:0] a;
      e = q.pop_front();
      a = {state_dbg, mem_req, mem_we, i_or_d,
           ir_write, pc_write, reg_write,
           reg_dst, mem_to_reg, ext_sel, alu_src_a,
           alu_src_b, alu_op, pc_src, illegal};
      n_run++;
      if (a !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", e.nm, a, e.v);
      end
    end
  end

  task automatic step(
    input logic       r,
    input logic [5:0] op,
    input logic       z,
    input logic       rdy,
    input state_e     st,
    input logic [5:0] we,
    input logic [3:0] sel,
    input logic [1:0] asb,
    input logic [2:0] aop,
    input logic [1:0] pcs,
    input logic       ill,
    input string      nm
  );
    exp_t e;
    rst       = r;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    e.v  = {4'(st), we, sel, asb, aop, pcs, ill};
    e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Fetch with a ready memory, then decode; shared by most cases.
  task automatic fetch_decode(input logic [5:0] op, input string nm);
    step(0, op, 0, 1, S_FETCH, 6'b100110, 4'b0000,
         ALUSRCB_FOUR, ALU_OP_ADD, PCSRC_ALU, 0, {nm, ".fetch"});
    step(0, op, 0, 1, S_DECODE, 6'b000000, 4'b0000,
         ALUSRCB_IMM_SH2, ALU_OP_ADD, PCSRC_ALU, 0, {nm, ".decode"});
  endtask

  initial begin
    rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(1, 6'h00, 0, 1, S_FETCH, 6'b0, 4'b0,
         2'b00, ALU_OP_ADD, 2'b00, 0, "reset0");
    step(1, 6'h00, 1, 1, S_FETCH, 6'b0, 4'b0,
         2'b00, ALU_OP_ADD, 2'b00, 0, "reset1");

    // lw, no memory wait
    fetch_decode(6'b100011, "lw");
    step(0, 6'b100011, 0, 1, S_MEMADR, 6'b000000, 4'b0001,
         ALUSRCB_IMM, ALU_OP_ADD, PCSRC_ALU, 0, "lw.memadr");
    step(0, 6'b100011, 0, 1, S_MEMRD, 6'b101000, 4'b0000,
         2'b00, ALU_OP_ADD, PCSRC_ALU, 0, "lw.memrd");
    step(0, 6'b100011, 0, 1, S_MEMWB, 6'b000001, 4'b0100,
         2'b00, ALU_OP_ADD, PCSRC_ALU, 0, "lw.memwb");

    // R-type with three fetch wait cycles
    for (int i = 0; i < 3; i++)
      step(0, 6'b000000, 0, 0, S_FETCH, 6'b100000, 4'b0000,
           ALUSRCB_FOUR, ALU_OP_ADD, PCSRC_ALU, 0, "r.fwait");
    fetch_decode(6'b000000, "r");
    step(0, 6'b000000, 0, 1, S_EXEC, 6'b000000, 4'b0001,
         ALUSRCB_RT, ALU_OP_FUNCT, PCSRC_ALU, 0, "r.exec");
    step(0, 6'b000000, 0, 1, S_ALUWB, 6'b000001, 4'b1000,
         2'b00, ALU_OP_ADD, PCSRC_ALU, 0, "r.aluwb");

    // branches: beq/bne with both zero values
    fetch_decode(6'b000100, "beq1");
    step(0, 6'b000100, 1, 0, S_BRANCH, 6'b000010, 4'b0001,
         ALUSRCB_RT, ALU_OP_SUB, PCSRC_ALUOUT, 0, "beq1.br");
    fetch_decode(6'b000101, "bne1");
    step(0, 6'b000101, 1, 0, S_BRANCH, 6'b000000, 4'b0001,
         ALUSRCB_RT, ALU_OP_SUB, PCSRC_ALUOUT, 0, "bne1.br");
    fetch_decode(6'b000100, "beq0");
    step(0, 6'b000100, 0, 0, S_BRANCH, 6'b000000, 4'b0001,
         ALUSRCB_RT, ALU_OP_SUB, PCSRC_ALUOUT, 0, "beq0.br");
    fetch_decode(6'b000101, "bne0");
    step(0, 6'b000101, 0, 0, S_BRANCH, 6'b000010, 4'b0001,
         ALUSRCB_RT, ALU_OP_SUB, PCSRC_ALUOUT, 0, "bne0.br");

    // immediate ALU ops
    fetch_decode(6'b001101, "ori");
    step(0, 6'b001101, 0, 1, S_IMMEXEC, 6'b000000, 4'b0011,
         ALUSRCB_IMM, ALU_OP_OR, PCSRC_ALU, 0, "ori.exec");
    step(0, 6'b001101, 0, 1, S_IMMWB, 6'b000001, 4'b0010,
         2'b00, ALU_OP_OR, PCSRC_ALU, 0, "ori.wb");
    fetch_decode(6'b001100, "andi");
    step(0, 6'b001100, 0, 1, S_IMMEXEC, 6'b000000, 4'b0011,
         ALUSRCB_IMM, ALU_OP_AND, PCSRC_ALU, 0, "andi.exec");
    step(0, 6'b001100, 0, 1, S_IMMWB, 6'b000001, 4'b0010,
         2'b00, ALU_OP_AND, PCSRC_ALU, 0, "andi.wb");
    fetch_decode(6'b001000, "addi");
    step(0, 6'b001000, 0, 1, S_IMMEXEC, 6'b000000, 4'b0001,
         ALUSRCB_IMM, ALU_OP_ADD, PCSRC_ALU, 0, "addi.exec");
    step(0, 6'b001000, 0, 1, S_IMMWB, 6'b000001, 4'b0000,
         2'b00, ALU_OP_ADD, PCSRC_ALU, 0, "addi.wb");

    // jump
    fetch_decode(6'b000010, "j");
    step(0, 6'b000010, 0, 1, S_JUMP, 6'b000010, 4'b0000,
         2'b00, ALU_OP_ADD, PCSRC_JUMP, 0, "j.jump");

    // sw with one memory wait
    fetch_decode(6'b101011, "sw");
    step(0, 6'b101011, 0, 1, S_MEMADR, 6'b000000, 4'b0001,
         ALUSRCB_IMM, ALU_OP_ADD, PCSRC_ALU, 0, "sw.memadr");
    step(0, 6'b101011, 0, 0, S_MEMWR, 6'b111000, 4'b0000,
         2'b00, ALU_OP_ADD, PCSRC_ALU, 0, "sw.wait");
    step(0, 6'b101011, 0, 1, S_MEMWR, 6'b111000, 4'b0000,
         2'b00, ALU_OP_ADD, PCSRC_ALU, 0, "sw.memwr");

    // sw aborted by reset mid-access
    fetch_decode(6'b101011, "swr");
    step(0, 6'b101011, 0, 0, S_MEMADR, 6'b000000, 4'b0001,
         ALUSRCB_IMM, ALU_OP_ADD, PCSRC_ALU, 0, "swr.memadr");
    step(0, 6'b101011, 0, 0, S_MEMWR, 6'b111000, 4'b0000,
         2'b00, ALU_OP_ADD, PCSRC_ALU, 0, "swr.memwr");
    step(1, 6'b101011, 0, 1, S_FETCH, 6'b000000, 4'b0000,
         2'b00, ALU_OP_ADD, PCSRC_ALU, 0, "swr.rst");
    step(1, 6'b101011, 0, 1, S_FETCH, 6'b000000, 4'b0000,
         2'b00, ALU_OP_ADD, PCSRC_ALU, 0, "swr.rst2");
    step(0, 6'b101011, 0, 0, S_FETCH, 6'b100000, 4'b0000,
         ALUSRCB_FOUR, ALU_OP_ADD, PCSRC_ALU, 0, "swr.refetch");

    // unknown opcode
    fetch_decode(6'b111111, "ill");
`ifdef MC_ILLEGAL_TRAP_EN
    step(0, 6'b111111, 0, 1, S_TRAP, 6'b000010, 4'b0000,
         2'b00, ALU_OP_ADD, PCSRC_EXC, 1, "ill.trap");
`endif
    step(0, 6'b111111, 0, 0, S_FETCH, 6'b100000, 4'b0000,
         ALUSRCB_FOUR, ALU_OP_ADD, PCSRC_ALU, 0, "ill.fetch");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
